// File: rtl/vga_frame_writer_if.sv
// Pixel-stream and frame-memory write bundle for the VGA frame writer.
// Latency: none (wires only).
// Backpressure: pix_ready is the only stall signal; memory writes are never stalled.
interface vga_frame_writer_if #(
    parameter int ADDR_W = 11
);
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              flush;
    logic              clear;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              frame_done;
    logic              clear_done;
    logic              busy;

    // Pixel source / controller side.
    modport master (
        output pix_data, pix_valid, flush, clear,
        input  pix_ready, mem_we, mem_addr, mem_data, frame_done, clear_done, busy
    );

    // Frame writer side.
    modport slave (
        input  pix_data, pix_valid, flush, clear,
        output pix_ready, mem_we, mem_addr, mem_data, frame_done, clear_done, busy
    );
endinterface

// File: rtl/vga_frame_writer.sv
// Packs 8-bit grey pixels MSB-first into 32-bit words and writes them to frame memory; also flush and full clear.
// Latency: 4th byte (or flush) accepted on edge N -> mem_we during cycle N+1; clear takes DEPTH write cycles.
// Backpressure: pix_ready drops during WRITE/CLEAR and when clear is high; memory side never stalls.
module vga_frame_writer #(
    parameter int          ADDR_W = 11,
    parameter int          DEPTH  = 2048,
    parameter logic [31:0] FILL   = 32'h0000_0000,
    parameter logic [7:0]  PAD    = 8'h00
) (
    input  logic              clock,
    input  logic              reset_n,
    vga_frame_writer_if.slave bus
);

    typedef enum logic [1:0] {
        S_PACK  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_lane;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [31:0]       r_word;
    logic              r_clr_pend;
    logic [ADDR_W-1:0] r_hold_addr;
    logic [31:0]       r_hold_data;

    logic              w_in_pack;
    logic              w_pix_ready;
    logic              w_accept;
    logic [2:0]        w_cnt;
    logic              w_word_done;
    logic              w_flush_go;
    logic [31:0]       w_word_acc;
    logic [31:0]       w_word_nxt;

    assign w_in_pack   = (r_state == S_PACK);
    // reset_n gating keeps ready low while held in reset even though the state reads PACK.
    assign w_pix_ready = w_in_pack & reset_n & ~bus.clear;
    assign w_accept    = bus.pix_valid & w_pix_ready;
    assign w_cnt       = {1'b0, r_lane} + {2'b00, w_accept};
    assign w_word_done = w_accept & (r_lane == 2'd3);
    // A flush landing with the 4th byte is absorbed: that word goes out through w_word_done.
    assign w_flush_go  = w_in_pack & ~bus.clear & bus.flush & (w_cnt != 3'd0) & (w_cnt != 3'd4);

    // Merge the accepted byte into its lane, then pad the unfilled lanes on a flush.
    always_comb begin
        w_word_acc = r_word;
        if (w_accept) begin
            case (r_lane)
                2'd0:    w_word_acc[31:24] = bus.pix_data;
                2'd1:    w_word_acc[23:16] = bus.pix_data;
                2'd2:    w_word_acc[15:8]  = bus.pix_data;
                default: w_word_acc[7:0]   = bus.pix_data;
            endcase
        end
        w_word_nxt = w_word_acc;
        if (w_flush_go) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= int'(w_cnt)) begin
                    w_word_nxt[31-8*i -: 8] = PAD;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_PACK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: clear beats flush beats pixel accept while packing.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_PACK: begin
                if (bus.clear) begin
                    w_state_nxt = S_CLEAR;
                end else if (w_word_done | w_flush_go) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_nxt = (bus.clear | r_clr_pend) ? S_CLEAR : S_PACK;
            end
            S_CLEAR: begin
                if (r_clr_ptr == LAST_ADDR) begin
                    w_state_nxt = S_PACK;
                end
            end
            default: w_state_nxt = S_PACK;
        endcase
    end

    // Pack register, pointers and the last-write hold registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lane      <= 2'd0;
            r_wptr      <= '0;
            r_clr_ptr   <= '0;
            r_word      <= 32'd0;
            r_clr_pend  <= 1'b0;
            r_hold_addr <= '0;
            r_hold_data <= 32'd0;
        end else begin
            case (r_state)
                S_PACK: begin
                    if (bus.clear) begin
                        r_lane <= 2'd0;
                    end else begin
                        r_word <= w_word_nxt;
                        if (w_accept) begin
                            r_lane <= r_lane + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    r_hold_addr <= r_wptr;
                    r_hold_data <= r_word;
                    r_wptr      <= r_wptr + 1'b1;
                    r_lane      <= 2'd0;
                    if (bus.clear) begin
                        r_clr_pend <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_clr_pend  <= 1'b0;
                    r_hold_addr <= r_clr_ptr;
                    r_hold_data <= FILL;
                    if (r_clr_ptr == LAST_ADDR) begin
                        r_clr_ptr <= '0;
                        r_wptr    <= '0;
                        r_lane    <= 2'd0;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + 1'b1;
                    end
                end
                default: begin
                    r_lane <= 2'd0;
                end
            endcase
        end
    end

    // Outputs decode registered state; address/data hold the last write when idle.
    assign bus.pix_ready  = w_pix_ready;
    assign bus.mem_we     = (r_state == S_WRITE) | (r_state == S_CLEAR);
    assign bus.mem_addr   = (r_state == S_WRITE) ? r_wptr :
                            (r_state == S_CLEAR) ? r_clr_ptr : r_hold_addr;
    assign bus.mem_data   = (r_state == S_WRITE) ? r_word :
                            (r_state == S_CLEAR) ? FILL : r_hold_data;
    assign bus.frame_done = (r_state == S_WRITE) & (r_wptr == LAST_ADDR);
    assign bus.clear_done = (r_state == S_CLEAR) & (r_clr_ptr == LAST_ADDR);
    assign bus.busy       = (r_state != S_PACK) | r_clr_pend;

endmodule
